// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master bridge: turns a simple read/write burst
// command into AR/R or AW/W/B handshakes and reports completion with an error flag.
module axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  // command port
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        req_ready,
  // write-beat source
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_strb,
  input  logic        wd_valid,
  output logic        wd_ready,
  // read-beat sink
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  // completion
  output logic        done,
  output logic        err,
  // AR channel
  output logic [3:0]  M_ARID,
  output logic [31:0] M_ARAddr,
  output logic [3:0]  M_ARLen,
  output logic [2:0]  M_ARSize,
  output logic [1:0]  M_ARBurst,
  output logic        M_ARValid,
  input  logic        M_ARReady,
  // R channel
  input  logic [3:0]  M_RID,
  input  logic [31:0] M_RData,
  input  logic [1:0]  M_RResp,
  input  logic        M_RLast,
  input  logic        M_RValid,
  output logic        M_RReady,
  // AW channel
  output logic [3:0]  M_AWID,
  output logic [31:0] M_AWAddr,
  output logic [3:0]  M_AWLen,
  output logic [2:0]  M_AWSize,
  output logic [1:0]  M_AWBurst,
  output logic        M_AWValid,
  input  logic        M_AWReady,
  // W channel
  output logic [31:0] M_WData,
  output logic [3:0]  M_WStrb,
  output logic        M_WLast,
  output logic        M_WValid,
  input  logic        M_WReady,
  // B channel
  input  logic [3:0]  M_BID,
  input  logic [1:0]  M_BResp,
  input  logic        M_BValid,
  output logic        M_BReady
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  len_reg, len_next;
  logic        write_reg, write_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;

  logic accept, r_hs, w_hs, b_hs, last_cnt, r_beat_err, b_err, wdata_en;

  assign accept     = req_valid && (state_reg == IDLE);
  assign r_hs       = (state_reg == RDATA) && M_RValid;
  assign w_hs       = (state_reg == WDATA) && wd_valid && M_WReady;
  assign b_hs       = (state_reg == WRESP) && M_BValid;
  assign last_cnt   = (cnt_reg == len_reg);
  // An RLast that lands on the wrong beat still ends the burst but is flagged.
  assign r_beat_err = (M_RResp != 2'b00) || (M_RID != MASTER_ID) || (M_RLast && !last_cnt);
  assign b_err      = (M_BResp != 2'b00) || (M_BID != MASTER_ID);
  assign wdata_en   = (state_reg == WDATA);

  // State and burst-context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      len_reg   <= 4'd0;
      write_reg <= 1'b0;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      write_reg <= write_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    write_next = write_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next  = req_addr;
          len_next   = req_len;
          write_next = req_write;
          cnt_next   = 4'd0;
          err_next   = 1'b0;
          state_next = req_write ? WADDR : RADDR;
        end
      end
      RADDR: if (M_ARReady) state_next = RDATA;
      RDATA: begin
        if (r_hs) begin
          if (r_beat_err) err_next = 1'b1;
          if (M_RLast) begin
            cnt_next   = 4'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end
      WADDR: if (M_AWReady) state_next = WDATA;
      WDATA: begin
        if (w_hs) begin
          if (last_cnt) begin
            cnt_next   = 4'd0;
            state_next = WRESP;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end
      WRESP: if (M_BValid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: all handshake signals are decoded from the current state
  always_comb begin
    req_ready = (state_reg == IDLE);
    M_ARValid = (state_reg == RADDR);
    M_AWValid = (state_reg == WADDR);
    M_RReady  = (state_reg == RDATA);
    M_BReady  = (state_reg == WRESP);
    M_WValid  = wdata_en && wd_valid;
    M_WLast   = wdata_en && last_cnt;
    wd_ready  = wdata_en && M_WReady;
    rd_valid  = (state_reg == RDATA) && M_RValid;
    rd_last   = (state_reg == RDATA) && M_RLast;
    rd_data   = (state_reg == RDATA) ? M_RData : 32'd0;
    done      = (r_hs && M_RLast && !write_reg) || (b_hs && write_reg);
    err       = 1'b0;
    if (r_hs && M_RLast) err = err_reg || r_beat_err;
    if (b_hs)            err = err_reg || b_err;
    if (!done)           err = 1'b0;
  end

  // Address/command fields are always driven from the registered context
  assign M_ARID    = MASTER_ID;
  assign M_ARAddr  = addr_reg;
  assign M_ARLen   = len_reg;
  assign M_ARSize  = 3'b010;
  assign M_ARBurst = 2'b01;
  assign M_AWID    = MASTER_ID;
  assign M_AWAddr  = addr_reg;
  assign M_AWLen   = len_reg;
  assign M_AWSize  = 3'b010;
  assign M_AWBurst = 2'b01;

  // Per-lane write data/strobe pass-through, quiet outside WDATA
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
      assign M_WData[gi*8 +: 8] = wdata_en ? wd_data[gi*8 +: 8] : 8'd0;
      assign M_WStrb[gi]        = wdata_en && wd_strb[gi];
    end
  endgenerate

endmodule

// File: doc/axi_master_bridge.md
AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 Parameter MASTER_ID, default 4'd0: value driven on M_ARID and M_AWID.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid/req_write  input  1/1  command strobe; 1 = write burst, 0 = read burst.
REQ-005 req_addr/req_len  input  32/4  start byte address; beat count minus 1.
REQ-006 req_ready  output  1  command accepted when req_valid & req_ready.
REQ-007 wd_data/wd_strb/wd_valid  input  32/4/1  write-beat source; wd_ready  output  1.
REQ-008 rd_data/rd_valid/rd_last  output  32/1/1  read-beat sink; no backpressure.
REQ-009 done/err  output  1/1  one-cycle completion pulse; error flag valid with done.
REQ-010 AR channel: M_ARID 4, M_ARAddr 32, M_ARLen 4, M_ARSize 3, M_ARBurst 2, M_ARValid 1 outputs; M_ARReady 1 input.
REQ-011 R channel: M_RID 4, M_RData 32, M_RResp 2, M_RLast 1, M_RValid 1 inputs; M_RReady 1 output.
REQ-012 AW channel: M_AWID 4, M_AWAddr 32, M_AWLen 4, M_AWSize 3, M_AWBurst 2, M_AWValid 1 outputs; M_AWReady 1 input.
REQ-013 W channel: M_WData 32, M_WStrb 4, M_WLast 1, M_WValid 1 outputs; M_WReady 1 input.
REQ-014 B channel: M_BID 4, M_BResp 2, M_BValid 1 inputs; M_BReady 1 output.

Function
REQ-015 The FSM SHALL have states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, addr, len and write SHALL be registered; the beat counter SHALL be cleared. Next state: WADDR if write, else RADDR.
REQ-018 M_ARValid SHALL be 1 only in RADDR; RADDR->RDATA on M_ARValid & M_ARReady.
REQ-019 M_AWValid SHALL be 1 only in WADDR; WADDR->WDATA on M_AWValid & M_AWReady. No W beat is issued before the AW handshake.
REQ-020 AR/AW fields SHALL come from registered values; Size SHALL be 3'b010 and Burst SHALL be 2'b01 (INCR).
REQ-021 Each valid SHALL stay high until its handshake; fields SHALL hold stable while valid is high.
REQ-022 In RDATA, M_RReady SHALL be 1 and the beat SHALL pass combinationally: rd_data=M_RData, rd_valid=M_RValid, rd_last=M_RLast.
REQ-023 In WDATA: M_WValid = wd_valid; wd_ready = M_WReady; M_WData/M_WStrb pass through from wd_data/wd_strb; M_WLast = (cnt == len).
REQ-024 The 4-bit counter SHALL increment on each R or W handshake and clear on the last beat.
REQ-025 RDATA->IDLE SHALL occur on a handshake with M_RLast=1. WDATA->WRESP SHALL occur on a handshake with M_WLast=1.
REQ-026 In WRESP, M_BReady SHALL be 1; WRESP->IDLE on M_BValid.
REQ-027 done SHALL pulse for one cycle on the final R handshake or the B handshake.
REQ-028 err SHALL be 1 with done when any of the following occurred during the burst:
- RResp or BResp != 2'b00;
- M_RLast arrived at cnt != len;
- M_RID or M_BID != MASTER_ID.
REQ-029 An early M_RLast SHALL still terminate the burst.
REQ-030 len=0 SHALL give a single beat with Last asserted on beat 0.
REQ-031 Only one burst SHALL be outstanding at a time; req_valid outside IDLE is ignored.

Reset
REQ-032 While rst=0, the following SHALL be 0: state (IDLE), counter, all registered fields, all AXI valid/ready outputs, done, err.
REQ-033 Reset asserted mid-burst SHALL drop all valids immediately; no recovery of the interrupted burst.

Verification
REQ-034 Read, addr 0x0000_0100, len=3; slave returns 4 OKAY beats, RLast on beat 3 -> ARLen=3, 4 rd_valid pulses, rd_last on the 4th, done=1, err=0.
REQ-035 Write, len=0, wd_data 0xDEAD_BEEF; AWReady delayed 3 cycles -> no WValid before the AW handshake, WLast=1 on beat 0, done after B, err=0.
REQ-036 Write, len=1; M_WReady toggles 1,0,1; BResp=2'b10 -> 2 beats, data held while stalled, done=1 with err=1.
REQ-037 Read, len=3; slave asserts RLast on beat 1 -> FSM returns to IDLE, done=1, err=1.
REQ-038 rst pulsed low while in WDATA -> M_WValid=0 in the same cycle; req_ready=1 after release.
REQ-039 req_valid held high in RDATA with a different addr -> ignored; accepted only after the return to IDLE.
